// File: rtl/agc_pkg.sv
// Shared definitions for the AGC instruction sequencer: order-code fields,
// sequencer states, internal register addresses and word constants.
package agc_pkg;

    // Three-bit order codes held in B[14:12]
    localparam logic [2:0] OP_TC   = 3'd0;
    localparam logic [2:0] OP_TCF  = 3'd1;
    localparam logic [2:0] OP_RSV2 = 3'd2;
    localparam logic [2:0] OP_CA   = 3'd3;
    localparam logic [2:0] OP_CS   = 3'd4;
    localparam logic [2:0] OP_QC5  = 3'd5;
    localparam logic [2:0] OP_AD   = 3'd6;
    localparam logic [2:0] OP_MASK = 3'd7;

    // Quarter codes held in B[11:10]
    localparam logic [1:0] QC_00  = 2'd0;
    localparam logic [1:0] QC_RSV = 2'd1;
    localparam logic [1:0] QC_TS  = 2'd2;
    localparam logic [1:0] QC_XCH = 2'd3;

    typedef enum logic [3:0] {
        IDLE, FETCH, FETCH_W, DECODE, OPER, OPER_W, EXEC, WRITE, WRITE_W, HALT
    } agc_state_t;

    // Addresses that map onto internal registers instead of memory
    localparam logic [11:0] REG_A    = 12'd0;
    localparam logic [11:0] REG_L    = 12'd1;
    localparam logic [11:0] REG_Q    = 12'd2;
    localparam logic [11:0] REG_Z    = 12'd5;
    localparam logic [11:0] REG_ZERO = 12'd7;

    // One's-complement zeros in 15-bit memory format
    localparam logic [14:0] ONES_PZ = 15'o00000;
    localparam logic [14:0] ONES_NZ = 15'o77777;

    // 16-bit accumulator constants
    localparam logic [15:0] WORD_PLUS_ONE  = 16'o000001;
    localparam logic [15:0] WORD_MINUS_ONE = 16'o177776;
    localparam logic [15:0] WORD_NEG_ZERO  = 16'o177777;

    // Parity bit that gives the full 16-bit word an odd number of ones
    function automatic logic odd_par(input logic [14:0] d);
        return ~(^d);
    endfunction

    function automatic logic is_internal(input logic [11:0] k);
        return (k == REG_A) || (k == REG_L) || (k == REG_Q) ||
               (k == REG_Z) || (k == REG_ZERO);
    endfunction

endpackage

// File: rtl/agc_oc_add.sv
// 16-bit one's-complement adder with end-around carry. Negative zero is
// produced and passed through exactly as the carry chain yields it.
module agc_oc_add (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum
);
    logic [16:0] raw;

    // Binary add, then feed the carry out back into the low bit
    always_comb begin
        raw = {1'b0, a} + {1'b0, b};
        sum = raw[15:0] + {15'd0, raw[16]};
    end

endmodule

// File: rtl/agc_seq_core.sv
// Multi-cycle AGC instruction sequencer. Fetches over a req/ack memory port,
// executes a one's-complement order-code subset, and halts on bad parity.
module agc_seq_core #(
    parameter int                ADDR_W       = 12,
    parameter logic [ADDR_W-1:0] RESET_PC     = 12'o4000,
    parameter bit                PARITY_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic              retire,
    output logic              halted,
    output logic              parity_err,
    output logic              illegal_op,
    output logic [ADDR_W-1:0] dbg_z,
    output logic [15:0]       dbg_a
);
    import agc_pkg::*;

    agc_state_t        state;
    logic [15:0]       a;
    logic [14:0]       l, q, b, g, idx;
    logic              idx_pending;
    logic [ADDR_W-1:0] z;

    logic [2:0]        op;
    logic [1:0]        qc;
    logic [11:0]       k_raw;
    logic [ADDR_W-1:0] k;
    logic              is_ccs, needs_read, is_store, k_int;
    logic [14:0]       int_rd, store_w, ccs_mag;
    logic [15:0]       m_ext, add_a, add_b, add_sum, ccs_dec;
    logic              parity_fail;

    assign dbg_z = z;
    assign dbg_a = a;

    // Decode the instruction in B and derive operand address and helpers
    always_comb begin
        op         = b[14:12];
        qc         = b[11:10];
        is_ccs     = (op == OP_TCF) && (qc == QC_00);
        k_raw      = (is_ccs || op == OP_QC5) ? {2'b00, b[9:0]} : b[11:0];
        k          = ADDR_W'(k_raw);
        k_int      = is_internal(k_raw);
        is_store   = (op == OP_QC5) && qc[1];
        needs_read = is_ccs || (op == OP_CA) || (op == OP_CS) || (op == OP_AD) ||
                     (op == OP_MASK) ||
                     ((op == OP_QC5) && ((qc == QC_00) || (qc == QC_XCH)));
        case (k_raw)
            REG_A:   int_rd = {a[15], a[13:0]};
            REG_L:   int_rd = l;
            REG_Q:   int_rd = q;
            REG_Z:   int_rd = 15'(z);
            default: int_rd = ONES_PZ;
        endcase
        m_ext       = {g[14], g};
        ccs_mag     = g[14] ? ~g : g;
        store_w     = {a[15], a[13:0]};
        parity_fail = PARITY_CHECK && !(^mem_rdata);
    end

    // Steer the single adder: index add on fetch, decrement for CCS, else AD
    always_comb begin
        add_a = a;
        add_b = m_ext;
        if (state == FETCH_W) begin
            add_a = {mem_rdata[14], mem_rdata[14:0]};
            add_b = {idx[14], idx};
        end else if (is_ccs) begin
            add_a = {1'b0, ccs_mag};
            add_b = WORD_MINUS_ONE;
        end
        // |M| - 1 of a nonzero magnitude is never negative, so a -0 from
        // subtracting one from one is reported as +0
        ccs_dec = (add_sum == WORD_NEG_ZERO) ? 16'd0 : add_sum;
    end

    agc_oc_add u_add (
        .a   (add_a),
        .b   (add_b),
        .sum (add_sum)
    );

    // Sequencer FSM: fetch, operand access, execute, store, halt
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            z           <= RESET_PC;
            a           <= '0;
            l           <= '0;
            q           <= '0;
            b           <= '0;
            g           <= '0;
            idx         <= '0;
            idx_pending <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            retire      <= 1'b0;
            halted      <= 1'b0;
            parity_err  <= 1'b0;
            illegal_op  <= 1'b0;
        end else begin
            retire     <= 1'b0;
            illegal_op <= 1'b0;
            case (state)
                IDLE: begin
                    if (run) state <= FETCH;
                end
                FETCH: begin
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= z;
                    state    <= FETCH_W;
                end
                FETCH_W: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (parity_fail) begin
                            parity_err <= 1'b1;
                            halted     <= 1'b1;
                            state      <= HALT;
                        end else begin
                            b           <= idx_pending ? add_sum[14:0] : mem_rdata[14:0];
                            idx_pending <= 1'b0;
                            z           <= z + ADDR_W'(1);
                            state       <= DECODE;
                        end
                    end
                end
                DECODE: begin
                    if (needs_read && k_int) begin
                        g     <= int_rd;
                        state <= EXEC;
                    end else if (needs_read) begin
                        state <= OPER;
                    end else begin
                        state <= EXEC;
                    end
                end
                OPER: begin
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= k;
                    state    <= OPER_W;
                end
                OPER_W: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (parity_fail) begin
                            parity_err <= 1'b1;
                            halted     <= 1'b1;
                            state      <= HALT;
                        end else begin
                            g     <= mem_rdata[14:0];
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (is_store && k_int) begin
                        case (k_raw)
                            REG_A:   a <= {store_w[14], store_w};
                            REG_L:   l <= store_w;
                            REG_Q:   q <= store_w;
                            REG_Z:   z <= ADDR_W'(store_w);
                            default: ;
                        endcase
                    end
                    case (op)
                        OP_TC: begin
                            q <= 15'(z);
                            z <= k;
                        end
                        OP_TCF: begin
                            if (qc == QC_00) begin
                                if (g == ONES_PZ) begin
                                    a <= 16'd0;
                                    z <= z + ADDR_W'(1);
                                end else if (g == ONES_NZ) begin
                                    a <= 16'd0;
                                    z <= z + ADDR_W'(3);
                                end else if (g[14]) begin
                                    a <= ccs_dec;
                                    z <= z + ADDR_W'(2);
                                end else begin
                                    a <= ccs_dec;
                                end
                            end else begin
                                z <= k;
                            end
                        end
                        OP_CA:   a <= m_ext;
                        OP_CS:   a <= ~m_ext;
                        OP_AD:   a <= add_sum;
                        OP_MASK: a <= {a[14], a[14:0] & g};
                        OP_QC5: begin
                            case (qc)
                                QC_00: begin
                                    idx         <= g;
                                    idx_pending <= 1'b1;
                                end
                                QC_RSV: illegal_op <= 1'b1;
                                QC_TS: begin
                                    if (a[15] != a[14]) begin
                                        a <= a[15] ? WORD_MINUS_ONE : WORD_PLUS_ONE;
                                        z <= z + ADDR_W'(1);
                                    end
                                end
                                default: a <= m_ext;
                            endcase
                        end
                        default: illegal_op <= 1'b1;
                    endcase
                    if (is_store && !k_int) begin
                        mem_wdata <= {odd_par(store_w), store_w};
                        state     <= WRITE;
                    end else begin
                        retire <= 1'b1;
                        state  <= run ? FETCH : IDLE;
                    end
                end
                WRITE: begin
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b1;
                    mem_addr <= k;
                    state    <= WRITE_W;
                end
                WRITE_W: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        retire  <= 1'b1;
                        state   <= run ? FETCH : IDLE;
                    end
                end
                HALT: state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_agc_seq_core.sv
// Directed self-checking bench for agc_seq_core with a behavioural memory.
module tb_agc_seq_core;

    logic        clk, reset, run, mem_req, mem_we, mem_ack;
    logic [11:0] mem_addr, dbg_z;
    logic [15:0] mem_wdata, mem_rdata, dbg_a;
    logic        retire, halted, parity_err, illegal_op;

    int compared = 0;
    int mismatched = 0;

    logic [15:0] mem [0:4095];
    logic        auto_mem;
    int          lat, wait_cnt;
    int          retire_cnt, ill_cnt, write_cnt;
    logic [11:0] last_raddr, last_waddr;
    logic [15:0] last_wdata;

    agc_seq_core dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .retire     (retire),
        .halted     (halted),
        .parity_err (parity_err),
        .illegal_op (illegal_op),
        .dbg_z      (dbg_z),
        .dbg_a      (dbg_a)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global watchdog so a stuck run still ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Count retire and illegal pulses on each rising edge
    always @(posedge clk) begin
        if (retire) retire_cnt++;
        if (illegal_op) ill_cnt++;
    end

    // Memory responder: acks after lat idle cycles, one-cycle ack strobe
    initial begin
        mem_ack = 1'b0;
        mem_rdata = '0;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (auto_mem) begin
                if (mem_ack) begin
                    mem_ack = 1'b0;
                end else if (mem_req && !reset) begin
                    if (wait_cnt >= lat) begin
                        wait_cnt = 0;
                        mem_ack = 1'b1;
                        if (mem_we) begin
                            mem[mem_addr] = mem_wdata;
                            last_waddr = mem_addr;
                            last_wdata = mem_wdata;
                            write_cnt++;
                        end else begin
                            mem_rdata = mem[mem_addr];
                            last_raddr = mem_addr;
                        end
                    end else begin
                        wait_cnt++;
                    end
                end else begin
                    wait_cnt = 0;
                end
            end
        end
    end

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [11:0] k);
        logic [14:0] d;
        d = {op, k};
        return {~(^d), d};
    endfunction

    function automatic logic [15:0] dw(input logic [14:0] d);
        return {~(^d), d};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = mk(3'd1, 12'o7777);
    endtask

    task automatic do_reset(input int lat_val);
        reset = 1'b1;
        run = 1'b0;
        auto_mem = 1'b1;
        lat = lat_val;
        repeat (2) @(negedge clk);
        retire_cnt = 0;
        ill_cnt = 0;
        write_cnt = 0;
        reset = 1'b0;
        run = 1'b1;
    endtask

    task automatic wait_retire(input string name);
        bit seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (retire === 1'b1) seen = 1;
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s_retire: got no retire, want retire within 300 cycles", name);
        end
    endtask

    task automatic wait_req(input string name);
        bit seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1) seen = 1;
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s_req: got no mem_req, want mem_req within 50 cycles", name);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run = 1'b0;
        auto_mem = 1'b1;
        lat = 0;
        repeat (2) @(negedge clk);
        compared++; if (mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_req: got %b want 0", mem_req); end
        compared++; if (mem_we !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_we: got %b want 0", mem_we); end
        compared++; if (retire !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_retire: got %b want 0", retire); end
        compared++; if (halted !== 1'b0 || parity_err !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_halt: got %b%b want 00", halted, parity_err); end
        compared++; if (illegal_op !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_ill: got %b want 0", illegal_op); end
        compared++; if (dbg_z !== 12'o4000) begin mismatched++; $display("[TB] FAIL rst_z: got %o want 4000", dbg_z); end
        compared++; if (dbg_a !== 16'o0) begin mismatched++; $display("[TB] FAIL rst_a: got %o want 0", dbg_a); end
    endtask

    task automatic test_tc_entry();
        clear_mem();
        mem[12'o4000] = mk(3'd0, 12'o100);
        mem[12'o100]  = mk(3'd3, 12'o2);
        do_reset(0);
        wait_req("tc_first");
        compared++; if (mem_addr !== 12'o4000) begin mismatched++; $display("[TB] FAIL tc_addr: got %o want 4000", mem_addr); end
        compared++; if (mem_we !== 1'b0) begin mismatched++; $display("[TB] FAIL tc_we: got %b want 0", mem_we); end
        wait_retire("tc");
        compared++; if (dbg_z !== 12'o100) begin mismatched++; $display("[TB] FAIL tc_z: got %o want 100", dbg_z); end
        @(negedge clk);
        compared++; if (retire !== 1'b0) begin mismatched++; $display("[TB] FAIL tc_pulse: got %b want 0", retire); end
        wait_retire("tc_q");
        compared++; if (dbg_a !== 16'o004001) begin mismatched++; $display("[TB] FAIL tc_q: got %o want 004001", dbg_a); end
        compared++; if (dbg_z !== 12'o101) begin mismatched++; $display("[TB] FAIL tc_z2: got %o want 101", dbg_z); end
    endtask

    task automatic test_overflow();
        clear_mem();
        mem[12'o4000] = mk(3'd3, 12'o300);
        mem[12'o300]  = dw(15'o37777);
        mem[12'o4001] = mk(3'd6, 12'o301);
        mem[12'o301]  = dw(15'o00001);
        mem[12'o4002] = mk(3'd5, {2'b10, 10'o60});
        do_reset(1);
        wait_retire("ovf_ca");
        compared++; if (dbg_a !== 16'o037777) begin mismatched++; $display("[TB] FAIL ovf_ca: got %o want 037777", dbg_a); end
        wait_retire("ovf_ad");
        compared++; if (dbg_a !== 16'o040000) begin mismatched++; $display("[TB] FAIL ovf_ad: got %o want 040000", dbg_a); end
        wait_retire("ovf_ts");
        compared++; if (write_cnt !== 1) begin mismatched++; $display("[TB] FAIL ovf_wcnt: got %0d want 1", write_cnt); end
        compared++; if (last_waddr !== 12'o60) begin mismatched++; $display("[TB] FAIL ovf_waddr: got %o want 60", last_waddr); end
        compared++; if (last_wdata !== 16'h8000) begin mismatched++; $display("[TB] FAIL ovf_wdata: got %h want 8000", last_wdata); end
        compared++; if (dbg_a !== 16'o000001) begin mismatched++; $display("[TB] FAIL ovf_a: got %o want 000001", dbg_a); end
        compared++; if (dbg_z !== 12'o4004) begin mismatched++; $display("[TB] FAIL ovf_z: got %o want 4004", dbg_z); end
    endtask

    task automatic test_ccs();
        logic [14:0] m_vals [4];
        logic [11:0] exp_z [4];
        logic [15:0] exp_a [4];
        logic [11:0] pc;
        m_vals = '{15'o00005, 15'o00000, 15'o77772, 15'o77777};
        exp_z  = '{12'o4001, 12'o4003, 12'o4006, 12'o4012};
        exp_a  = '{16'o4, 16'o0, 16'o4, 16'o0};
        clear_mem();
        pc = 12'o4000;
        for (int i = 0; i < 4; i++) begin
            mem[pc] = mk(3'd1, {2'b00, 10'(12'o300 + i)});
            mem[12'o300 + i] = dw(m_vals[i]);
            pc = exp_z[i];
        end
        do_reset(2);
        for (int i = 0; i < 4; i++) begin
            wait_retire("ccs");
            compared++; if (dbg_a !== exp_a[i]) begin mismatched++; $display("[TB] FAIL ccs_a%0d: got %o want %o", i, dbg_a, exp_a[i]); end
            compared++; if (dbg_z !== exp_z[i]) begin mismatched++; $display("[TB] FAIL ccs_z%0d: got %o want %o", i, dbg_z, exp_z[i]); end
        end
    endtask

    task automatic test_index();
        clear_mem();
        mem[12'o4000] = mk(3'd5, {2'b00, 10'o400});
        mem[12'o400]  = dw(15'o00003);
        mem[12'o4001] = mk(3'd3, 12'o200);
        mem[12'o4002] = mk(3'd3, 12'o200);
        mem[12'o200]  = dw(15'o11111);
        mem[12'o203]  = dw(15'o12345);
        do_reset(1);
        wait_retire("idx");
        compared++; if (dbg_z !== 12'o4001) begin mismatched++; $display("[TB] FAIL idx_z: got %o want 4001", dbg_z); end
        wait_retire("idx_ca1");
        compared++; if (last_raddr !== 12'o203) begin mismatched++; $display("[TB] FAIL idx_addr1: got %o want 203", last_raddr); end
        compared++; if (dbg_a !== 16'o012345) begin mismatched++; $display("[TB] FAIL idx_a1: got %o want 012345", dbg_a); end
        wait_retire("idx_ca2");
        compared++; if (last_raddr !== 12'o200) begin mismatched++; $display("[TB] FAIL idx_addr2: got %o want 200", last_raddr); end
        compared++; if (dbg_a !== 16'o011111) begin mismatched++; $display("[TB] FAIL idx_a2: got %o want 011111", dbg_a); end
    endtask

    task automatic test_alu();
        clear_mem();
        mem[12'o4000] = mk(3'd3, 12'o300);
        mem[12'o300]  = dw(15'o25252);
        mem[12'o4001] = mk(3'd7, 12'o301);
        mem[12'o301]  = dw(15'o17017);
        mem[12'o4002] = mk(3'd4, 12'o302);
        mem[12'o302]  = dw(15'o00007);
        mem[12'o4003] = mk(3'd5, {2'b11, 10'o303});
        mem[12'o303]  = dw(15'o12345);
        do_reset(0);
        wait_retire("alu_ca");
        wait_retire("alu_mask");
        compared++; if (dbg_a !== 16'o005012) begin mismatched++; $display("[TB] FAIL alu_mask: got %o want 005012", dbg_a); end
        wait_retire("alu_cs");
        compared++; if (dbg_a !== 16'o177770) begin mismatched++; $display("[TB] FAIL alu_cs: got %o want 177770", dbg_a); end
        wait_retire("alu_xch");
        compared++; if (dbg_a !== 16'o012345) begin mismatched++; $display("[TB] FAIL alu_xch_a: got %o want 012345", dbg_a); end
        compared++; if (last_waddr !== 12'o303) begin mismatched++; $display("[TB] FAIL alu_xch_addr: got %o want 303", last_waddr); end
        compared++; if (last_wdata !== 16'hFFF8) begin mismatched++; $display("[TB] FAIL alu_xch_data: got %h want FFF8", last_wdata); end
    endtask

    task automatic test_illegal();
        clear_mem();
        mem[12'o4000] = mk(3'd2, 12'o0);
        mem[12'o4001] = mk(3'd5, {2'b01, 10'o0});
        do_reset(0);
        wait_retire("ill_op2");
        wait_retire("ill_qc01");
        @(negedge clk);
        compared++; if (ill_cnt !== 2) begin mismatched++; $display("[TB] FAIL ill_cnt: got %0d want 2", ill_cnt); end
        compared++; if (dbg_z !== 12'o4002) begin mismatched++; $display("[TB] FAIL ill_z: got %o want 4002", dbg_z); end
        compared++; if (dbg_a !== 16'o0) begin mismatched++; $display("[TB] FAIL ill_a: got %o want 0", dbg_a); end
    endtask

    task automatic test_parity();
        int req_seen = 0;
        bit hit = 0;
        clear_mem();
        mem[12'o4000] = 16'h0000;
        do_reset(0);
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge clk);
            if (halted === 1'b1) hit = 1;
        end
        compared++; if (halted !== 1'b1) begin mismatched++; $display("[TB] FAIL par_halted: got %b want 1", halted); end
        compared++; if (parity_err !== 1'b1) begin mismatched++; $display("[TB] FAIL par_err: got %b want 1", parity_err); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req !== 1'b0) req_seen++;
        end
        compared++; if (req_seen !== 0) begin mismatched++; $display("[TB] FAIL par_req: got %0d req cycles want 0", req_seen); end
        compared++; if (retire_cnt !== 0) begin mismatched++; $display("[TB] FAIL par_retire: got %0d want 0", retire_cnt); end
        compared++; if (dbg_z !== 12'o4000) begin mismatched++; $display("[TB] FAIL par_z: got %o want 4000", dbg_z); end
    endtask

    task automatic test_reset_mid();
        clear_mem();
        mem[12'o4000] = mk(3'd0, 12'o100);
        do_reset(0);
        auto_mem = 1'b0;
        mem_ack = 1'b0;
        wait_req("mid_first");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run = 1'b0;
        #1;
        compared++; if (mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_req_drop: got %b want 0", mem_req); end
        compared++; if (dbg_z !== 12'o4000) begin mismatched++; $display("[TB] FAIL mid_z: got %o want 4000", dbg_z); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        mem_rdata = mk(3'd0, 12'o1234);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        compared++; if (mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_late_req: got %b want 0", mem_req); end
        compared++; if (dbg_z !== 12'o4000) begin mismatched++; $display("[TB] FAIL mid_late_z: got %o want 4000", dbg_z); end
        compared++; if (retire_cnt !== 0) begin mismatched++; $display("[TB] FAIL mid_late_retire: got %0d want 0", retire_cnt); end
        auto_mem = 1'b1;
        run = 1'b1;
        wait_req("mid_restart");
        compared++; if (mem_addr !== 12'o4000) begin mismatched++; $display("[TB] FAIL mid_restart_addr: got %o want 4000", mem_addr); end
        wait_retire("mid_tc");
        compared++; if (dbg_z !== 12'o100) begin mismatched++; $display("[TB] FAIL mid_tc_z: got %o want 100", dbg_z); end
    endtask

    initial begin
        reset = 1'b1;
        run = 1'b0;
        auto_mem = 1'b1;
        lat = 0;
        retire_cnt = 0;
        ill_cnt = 0;
        write_cnt = 0;
        last_raddr = '0;
        last_waddr = '0;
        last_wdata = '0;
        test_reset();
        test_tc_entry();
        test_overflow();
        test_ccs();
        test_index();
        test_alu();
        test_illegal();
        test_parity();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
